av_burst_slave_ram: RTL and testbench

- Avalon-MM burst responder (slave) backed by an internal word-addressed RAM.
- Accepts single and burst reads/writes from the core's Avalon master; returns pipelined read data via readdatavalid.
- Sits on the data-memory side of the interconnect. Used both as on-chip data RAM and as the bench target for the master.
- Configurable wait states on command acceptance, to exercise master stall handling.

---
 rtl/av_burst_slave_ram.sv | 97 +++++++++
 tb/tb_av_burst_slave_ram.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/av_burst_slave_ram.sv
// av_burst_slave_ram: Avalon-MM burst slave backed by a word-addressed 32-bit RAM
//   in : clk, clrn (async active-low), av_address (byte addr), av_read, av_write,
//        av_writedata, av_byteenable, av_burstcount, av_beginbursttransfer (unused)
//   out: av_waitrequest (combinational), av_readdata, av_readdatavalid (registered)
module av_burst_slave_ram #(
   parameter int ADDR_WIDTH  = 10,
   parameter int MAX_BURST   = 16,
   parameter int WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        clrn,
   input  logic [31:0] av_address,
   input  logic        av_read,
   input  logic        av_write,
   input  logic [31:0] av_writedata,
   input  logic [3:0]  av_byteenable,
   input  logic [4:0]  av_burstcount,
   input  logic        av_beginbursttransfer,
   output logic        av_waitrequest,
   output logic [31:0] av_readdata,
   output logic        av_readdatavalid
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   typedef enum logic [1:0] {IDLE, WSTALL, WBURST, RBURST} state_t;
   state_t                r_state, w_next;
   logic [31:0]           r_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] r_ptr, w_aidx, w_widx;
   logic [4:0]            r_cnt, r_len, w_blen;
   logic [3:0]            r_wcnt;
   logic [31:0]           r_rdata;
   logic                  r_rvalid, w_req, w_idle, w_stall, w_acc, w_we, w_wait, w_unused;
   assign w_aidx = av_address[ADDR_WIDTH+1:2];
   assign w_req  = av_read | av_write;
   assign w_idle = (r_state == IDLE) || (r_state == WSTALL);
   // the wait counter only ever counts up to WAIT_STATES, so inequality marks the stall
   assign w_stall = w_idle && w_req && (r_wcnt != 4'(WAIT_STATES));
   assign w_acc   = clrn && w_idle && w_req && !w_stall;
   assign w_blen  = (av_burstcount == 5'd0) ? 5'd1 :
                    (av_burstcount > 5'(MAX_BURST)) ? 5'(MAX_BURST) : av_burstcount;
   assign w_unused = ^{av_beginbursttransfer, av_address[31:ADDR_WIDTH+2], av_address[1:0]};
   always_comb begin
      w_next = r_state;
      w_wait = 1'b1;
      w_we   = 1'b0;
      w_widx = w_aidx;
      case (r_state)
         IDLE, WSTALL: begin
            w_wait = w_stall;
            w_we   = w_acc && av_write;
            w_next = w_stall ? WSTALL : !w_acc ? IDLE : !av_write ? RBURST :
                     (w_blen == 5'd1) ? IDLE : WBURST;
         end
         WBURST: begin
            w_wait = 1'b0;
            w_we   = av_write;
            w_widx = r_ptr;
            // beat 0 went in at acceptance, so r_cnt+1 is the beat being committed
            w_next = (av_write && (r_cnt + 5'd2 == r_len)) ? IDLE : WBURST;
         end
         default: w_next = (r_cnt + 5'd1 == r_len) ? IDLE : RBURST;
      endcase
   end
   assign av_waitrequest   = !clrn || w_wait;
   assign av_readdata      = r_rdata;
   assign av_readdatavalid = r_rvalid;
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_len    <= '0;
         r_ptr    <= '0;
         r_wcnt   <= '0;
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_wcnt   <= w_stall ? r_wcnt + 4'd1 : 4'd0;
         r_rvalid <= (r_state == RBURST);
         if (r_state == RBURST)
            r_rdata <= r_mem[r_ptr];
         if (w_acc) begin
            r_len <= w_blen;
            r_cnt <= '0;
            r_ptr <= av_write ? w_aidx + ADDR_WIDTH'(1) : w_aidx;
         end else if ((r_state == RBURST) || ((r_state == WBURST) && av_write)) begin
            r_cnt <= r_cnt + 5'd1;
            r_ptr <= r_ptr + ADDR_WIDTH'(1);
         end
      end
   end
   // RAM has no reset; contents survive clrn
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (w_we && av_byteenable[i])
            r_mem[w_widx][8*i +: 8] <= av_writedata[8*i +: 8];
   end
endmodule

// File: tb/tb_av_burst_slave_ram.sv
// tb_av_burst_slave_ram: directed and random checks of av_burst_slave_ram against an array model
module tb_av_burst_slave_ram;
   logic        clk = 1'b0;
   logic        clrn [2];
   logic [31:0] av_address [2];
   logic [31:0] av_writedata [2];
   logic [31:0] av_readdata [2];
   logic        av_read [2];
   logic        av_write [2];
   logic        av_beginbursttransfer [2];
   logic        av_waitrequest [2];
   logic        av_readdatavalid [2];
   logic [3:0]  av_byteenable [2];
   logic [4:0]  av_burstcount [2];
   logic [31:0] m [2][64];
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   av_burst_slave_ram #(.ADDR_WIDTH(4), .MAX_BURST(16), .WAIT_STATES(0)) u0 (
      .clk(clk), .clrn(clrn[0]), .av_address(av_address[0]), .av_read(av_read[0]),
      .av_write(av_write[0]), .av_writedata(av_writedata[0]), .av_byteenable(av_byteenable[0]),
      .av_burstcount(av_burstcount[0]), .av_beginbursttransfer(av_beginbursttransfer[0]),
      .av_waitrequest(av_waitrequest[0]), .av_readdata(av_readdata[0]),
      .av_readdatavalid(av_readdatavalid[0]));

   av_burst_slave_ram #(.ADDR_WIDTH(6), .MAX_BURST(16), .WAIT_STATES(3)) u1 (
      .clk(clk), .clrn(clrn[1]), .av_address(av_address[1]), .av_read(av_read[1]),
      .av_write(av_write[1]), .av_writedata(av_writedata[1]), .av_byteenable(av_byteenable[1]),
      .av_burstcount(av_burstcount[1]), .av_beginbursttransfer(av_beginbursttransfer[1]),
      .av_waitrequest(av_waitrequest[1]), .av_readdata(av_readdata[1]),
      .av_readdatavalid(av_readdatavalid[1]));

   function automatic int dep(input int d);
      return d != 0 ? 64 : 16;
   endfunction

   function automatic int ws(input int d);
      return d != 0 ? 3 : 0;
   endfunction

   function automatic int blen(input logic [4:0] bc);
      return bc == 5'd0 ? 1 : bc > 5'd16 ? 16 : int'(bc);
   endfunction

   // random alias bits above the index and random ignored byte-offset bits
   function automatic logic [31:0] addr(input int d, input int w);
      return 32'(w * 4 + dep(d) * 4 * int'($urandom_range(0, 255)) + int'($urandom_range(0, 3)));
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic put(input int d, input int i, input logic [31:0] v, input logic [3:0] be);
      for (int b = 0; b < 4; b++)
         if (be[b]) m[d][i][8*b +: 8] = v[8*b +: 8];
   endtask

   task automatic wait_acc(input int d);
      int n;
      n = 0;
      #1;
      while (av_waitrequest[d] && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk($sformatf("wait_states%0d", d), 32'(n), 32'(ws(d)));
   endtask

   task automatic wr(input int d, input int base, input logic [4:0] bc, input logic [3:0] be,
                     input bit rnd, input logic [31:0] d0, input bit also_rd,
                     input int pause_at, input int pause_len);
      logic [31:0] v;
      int          bl;
      bl = blen(bc);
      v = rnd ? $urandom : d0;
      av_address[d] = addr(d, base);
      av_read[d] = also_rd;
      av_write[d] = 1'b1;
      av_writedata[d] = v;
      av_byteenable[d] = be;
      av_burstcount[d] = bc;
      av_beginbursttransfer[d] = 1'b1;
      wait_acc(d);
      put(d, base, v, be);
      for (int k = 1; k < bl; k++) begin
         for (int p = 0; p < ((k == pause_at) ? pause_len : 0); p++) begin
            @(negedge clk);
            av_write[d] = 1'b0;
            av_read[d] = 1'b0;
            av_beginbursttransfer[d] = 1'b0;
            #1;
            chk("wb_pause_wreq", 32'(av_waitrequest[d]), 0);
         end
         @(negedge clk);
         v = rnd ? $urandom : d0 + 32'(k);
         av_read[d] = 1'b0;
         av_beginbursttransfer[d] = 1'b0;
         av_write[d] = 1'b1;
         av_writedata[d] = v;
         av_address[d] = $urandom;
         #1;
         chk("wb_wreq", 32'(av_waitrequest[d]), 0);
         put(d, (base + k) % dep(d), v, be);
      end
      @(negedge clk);
      av_write[d] = 1'b0;
      av_read[d] = 1'b0;
      av_beginbursttransfer[d] = 1'b0;
   endtask

   task automatic rd(input int d, input int base, input logic [4:0] bc, output logic [31:0] last);
      int bl;
      bl = blen(bc);
      last = '0;
      av_address[d] = addr(d, base);
      av_read[d] = 1'b1;
      av_burstcount[d] = bc;
      av_beginbursttransfer[d] = 1'b1;
      wait_acc(d);
      @(negedge clk);
      av_read[d] = 1'b0;
      av_beginbursttransfer[d] = 1'b0;
      #1;
      chk("rd_latency", 32'(av_readdatavalid[d]), 0);
      chk("rd_busy", 32'(av_waitrequest[d]), 1);
      for (int k = 0; k < bl; k++) begin
         @(negedge clk);
         #1;
         chk($sformatf("rd_valid%0d", k), 32'(av_readdatavalid[d]), 1);
         chk($sformatf("rd_data%0d", k), av_readdata[d], m[d][(base + k) % dep(d)]);
         chk($sformatf("rd_wreq%0d", k), 32'(av_waitrequest[d]), (k < bl - 1) ? 1 : 0);
         last = av_readdata[d];
      end
      @(negedge clk);
      #1;
      chk("rd_end", 32'(av_readdatavalid[d]), 0);
      chk("rd_hold", av_readdata[d], last);
   endtask

   initial begin
      logic [31:0] got;
      logic [4:0]  bc;
      int          d, b;
      for (int i = 0; i < 2; i++) begin
         clrn[i] = 1'b1;
         av_address[i] = '0;
         av_read[i] = 1'b0;
         av_write[i] = 1'b0;
         av_writedata[i] = '0;
         av_byteenable[i] = '0;
         av_burstcount[i] = '0;
         av_beginbursttransfer[i] = 1'b0;
      end
      #1;
      clrn[0] = 1'b0;
      clrn[1] = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("reset_wreq", 32'(av_waitrequest[i]), 1);
         chk("reset_valid", 32'(av_readdatavalid[i]), 0);
         chk("reset_rdata", av_readdata[i], 0);
      end
      @(negedge clk);
      clrn[0] = 1'b1;
      clrn[1] = 1'b1;
      for (int i = 0; i < 2; i++)
         for (int w = 0; w < dep(i); w += 16)
            wr(i, w, 5'd16, 4'hF, 1'b1, 0, 1'b0, 0, 0);
      wr(0, 0, 5'd1, 4'hF, 1'b0, 32'hDEADBEEF, 1'b0, 0, 0);
      rd(0, 0, 5'd1, got);
      chk("single", got, 32'hDEADBEEF);
      wr(0, 3, 5'd1, 4'hF, 1'b0, 32'h11223344, 1'b0, 0, 0);
      wr(0, 3, 5'd1, 4'b0101, 1'b0, 32'hAABBCCDD, 1'b0, 0, 0);
      rd(0, 3, 5'd1, got);
      chk("byteenable", got, 32'h11BB33DD);
      wr(0, 4, 5'd8, 4'hF, 1'b0, 32'h100, 1'b0, 0, 0);
      rd(0, 4, 5'd8, got);
      chk("burst_last", got, 32'h107);
      wr(0, 14, 5'd4, 4'hF, 1'b1, 0, 1'b0, 2, 2);
      rd(0, 14, 5'd4, got);
      wr(0, 2, 5'd20, 4'hF, 1'b1, 0, 1'b0, 0, 0);
      rd(0, 0, 5'd16, got);
      wr(1, 9, 5'd0, 4'hF, 1'b0, 32'hCAFEF00D, 1'b1, 0, 0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #1;
         chk("prio_no_rvalid", 32'(av_readdatavalid[1]), 0);
      end
      rd(1, 9, 5'd0, got);
      chk("prio_data", got, 32'hCAFEF00D);
      av_address[0] = addr(0, 2);
      av_read[0] = 1'b1;
      av_burstcount[0] = 5'd8;
      wait_acc(0);
      @(negedge clk);
      av_read[0] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         chk("rst_pre_valid", 32'(av_readdatavalid[0]), 1);
         chk("rst_pre_data", av_readdata[0], m[0][(2 + k) % 16]);
      end
      #2;
      clrn[0] = 1'b0;
      #1;
      chk("rst_valid", 32'(av_readdatavalid[0]), 0);
      chk("rst_wreq", 32'(av_waitrequest[0]), 1);
      chk("rst_rdata", av_readdata[0], 0);
      @(negedge clk);
      clrn[0] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #1;
         chk("rst_quiet", 32'(av_readdatavalid[0]), 0);
      end
      rd(0, 5, 5'd1, got);
      for (int i = 0; i < 40; i++) begin
         d = int'($urandom_range(0, 1));
         b = int'($urandom_range(0, dep(d) - 1));
         bc = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 1) != 0)
            wr(d, b, bc, 4'($urandom), 1'b1, 0, 1'b0, int'($urandom_range(1, 15)), int'($urandom_range(0, 2)));
         else
            rd(d, b, bc, got);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
